// File: rtl/xge_pkt_pkg.sv
// xge_pkt_pkg: lane constants, packed word struct and packer states for the pkt_tx path
package xge_pkt_pkg;

    localparam int WORD_W = 64;
    localparam int LANE_W = 8;
    localparam logic [2:0] LANE_LAST = 3'd7;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              sop;
        logic              eop;
        logic [2:0]        mod;
    } pkt_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PACK,
        ST_DISCARD
    } tx_state_t;

    // Byte index 0 lands in the most significant lane of the word
    function automatic logic [WORD_W-1:0] lane_insert(
        input logic [WORD_W-1:0] acc,
        input logic [2:0]        idx,
        input logic [7:0]        b
    );
        logic [WORD_W-1:0] w;
        w = acc;
        w[WORD_W-1-LANE_W*int'(idx) -: LANE_W] = b;
        return w;
    endfunction

endpackage

// File: rtl/pkt_tx_word_fifo.sv
// pkt_tx_word_fifo: two-entry word FIFO decoupling the packer from MAC backpressure
module pkt_tx_word_fifo
    import xge_pkt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  pkt_word_t  push_word,
    input  logic       pop,
    output pkt_word_t  head,
    output logic [1:0] count
);

    pkt_word_t  mem_q [2];
    pkt_word_t  mem_d [2];
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    // Pushes into a full FIFO and pops from an empty one are ignored
    always_comb begin
        do_push = push && count_q != 2'd2;
        do_pop  = pop && count_q != 2'd0;
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = push_word;
        wr_d    = wr_q ^ do_push;
        rd_d    = rd_q ^ do_pop;
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = count_q;

endmodule

// File: rtl/pkt_tx_packer.sv
// pkt_tx_packer: packs a byte stream into 64-bit xge_mac pkt_tx words with truncation of oversize frames
module pkt_tx_packer
    import xge_pkt_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = 9600,
    parameter int CNT_W           = 32
) (
    input  logic             clk_156m25,
    input  logic             reset_156m25,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    input  logic             pkt_tx_full,
    output logic [63:0]      pkt_tx_data,
    output logic             pkt_tx_val,
    output logic             pkt_tx_sop,
    output logic             pkt_tx_eop,
    output logic [2:0]       pkt_tx_mod,
    output logic             trunc_err,
    output logic [CNT_W-1:0] tx_frame_count
);

    localparam int BC_W = $clog2(MAX_FRAME_BYTES + 1);

    tx_state_t        state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [63:0]      acc_q, acc_d;
    logic             first_q, first_d;
    logic [BC_W-1:0]  bcnt_q, bcnt_d, bcnt_inc;
    logic             trunc_q, trunc_d;
    logic [63:0]      data_q, data_d;
    logic             val_q, val_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic [2:0]       mod_q, mod_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             accept, packing, trunc, last_eff, push, pop;
    pkt_word_t        push_word, head;
    logic [1:0]       fifo_count;

    assign s_ready = !reset_156m25 && (state_q == ST_DISCARD || fifo_count != 2'd2);

    // Byte packing, truncation detection and frame state
    always_comb begin
        accept         = s_valid && s_ready;
        packing        = accept && state_q != ST_DISCARD;
        bcnt_inc       = bcnt_q + BC_W'(1);
        trunc          = packing && !s_last && bcnt_inc == BC_W'(MAX_FRAME_BYTES);
        last_eff       = s_last || trunc;
        push           = packing && (idx_q == LANE_LAST || last_eff);
        push_word.data = lane_insert(acc_q, idx_q, s_data);
        push_word.sop  = first_q || state_q == ST_IDLE;
        push_word.eop  = last_eff;
        push_word.mod  = idx_q + 3'd1;
        idx_d          = packing ? (push ? 3'd0 : idx_q + 3'd1) : idx_q;
        acc_d          = packing ? (push ? '0 : push_word.data) : acc_q;
        first_d        = packing ? !push && push_word.sop : first_q;
        bcnt_d         = packing ? (last_eff ? '0 : bcnt_inc) : bcnt_q;
        trunc_d        = trunc;
        state_d        = state_q == ST_DISCARD ? (accept && s_last ? ST_IDLE : ST_DISCARD) :
                         !packing ? state_q :
                         trunc ? ST_DISCARD :
                         s_last ? ST_IDLE : ST_PACK;
    end

    // Output stage pops one word per edge whenever the MAC has room
    always_comb begin
        pop    = fifo_count != 2'd0 && !pkt_tx_full;
        val_d  = pop;
        data_d = pop ? head.data : data_q;
        sop_d  = pop ? head.sop : sop_q;
        eop_d  = pop ? head.eop : eop_q;
        mod_d  = pop ? head.mod : mod_q;
        fcnt_d = fcnt_q + CNT_W'(pop && head.eop);
    end

    pkt_tx_word_fifo u_fifo (
        .clk       (clk_156m25),
        .rst       (reset_156m25),
        .push      (push),
        .push_word (push_word),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    // Packer state and registered MAC-side outputs
    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            acc_q   <= '0;
            first_q <= 1'b0;
            bcnt_q  <= '0;
            trunc_q <= 1'b0;
            data_q  <= '0;
            val_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            mod_q   <= 3'd0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            first_q <= first_d;
            bcnt_q  <= bcnt_d;
            trunc_q <= trunc_d;
            data_q  <= data_d;
            val_q   <= val_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            mod_q   <= mod_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign pkt_tx_data    = data_q;
    assign pkt_tx_val     = val_q;
    assign pkt_tx_sop     = sop_q;
    assign pkt_tx_eop     = eop_q;
    assign pkt_tx_mod     = mod_q;
    assign trunc_err      = trunc_q;
    assign tx_frame_count = fcnt_q;

endmodule
